sobel_stream: RTL and testbench

Parameterised streaming 3x3 Sobel edge detector for raster RGB pixels. It is the successor to the fixed-size `sobel_mod`. It converts each pixel to grey and buffers two image lines internally. It emits one gradient-magnitude pixel per input pixel, replicated on all three colour outputs, with a self-generated flush at end of frame. It sits between the BMP pixel source and the result writer in the image pipeline.

---
 rtl/sobel_stream.sv | 211 +++++++++++++++++++++
 tb/tb_sobel_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: RGB -> grey, two line buffers, |Gx|+|Gy| magnitude.
// Optional build macro SOBEL_THRESH_EN binarises the magnitude against thresh_i.
module sobel_stream #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_red_i,
  input  logic [DATA_W-1:0] data_green_i,
  input  logic [DATA_W-1:0] data_blue_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] thresh_i,
  output logic [DATA_W-1:0] sobel_red_o,
  output logic [DATA_W-1:0] sobel_green_o,
  output logic [DATA_W-1:0] sobel_blue_o,
  output logic              sobel_done_o,
  output logic              sobel_eof_o,
  output logic              busy_o
);
  localparam int PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int PW  = $clog2(PIX + 1);
  localparam int FW  = $clog2(IMG_WIDTH + 1);
  localparam int GW  = DATA_W + 4;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [PW-1:0]           in_cnt_q, in_cnt_d;
  logic [FW-1:0]           fl_cnt_q, fl_cnt_d;
  logic [CW-1:0]           oc_q, oc_d;
  logic [RW-1:0]           or_q, or_d;
  logic [DATA_W-1:0]       win_q [9];
  logic [DATA_W-1:0]       win_d [9];
  logic                    trig_q, border_q, last_q;
  logic                    border_d, last_d;
  logic signed [GW-1:0]    gx_q, gy_q, gx_d, gy_d;
  logic                    v1_q, border1_q, last1_q;
  logic [DATA_W-1:0]       out_q, out_d;
  logic                    done_q, eof_q, busy_q, eof_d, busy_d;

  logic                    flushing, accept, trigger;
  logic [DATA_W+1:0]       gray_sum;
  logic [DATA_W-1:0]       pix_in;
  logic [DATA_W-1:0]       lb0_mem [IMG_WIDTH];
  logic [DATA_W-1:0]       lb1_mem [IMG_WIDTH];
  logic [DATA_W-1:0]       lb0_rd_q, lb1_rd_q;
  logic signed [GW-1:0]    p [9];
  logic [GW-1:0]           ax, ay, mag;
  logic [DATA_W-1:0]       mag_sat, result;

  assign gray_sum = {2'b00, data_red_i} + {1'b0, data_green_i, 1'b0} + {2'b00, data_blue_i};
  assign flushing = (state_q == FLUSH);
  assign accept   = flushing | data_valid_i;
  assign trigger  = flushing | ((state_q == RUN) & data_valid_i);
  assign pix_in   = flushing ? '0 : gray_sum[DATA_W+1:2];

  // Read address follows col_d so the registered read already holds the
  // column the next accept will consume, with or without input gaps.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_q] <= pix_in;
      lb1_mem[col_q] <= lb0_rd_q;
    end
    lb0_rd_q <= lb0_mem[col_d];
    lb1_rd_q <= lb1_mem[col_d];
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    fl_cnt_d = fl_cnt_q;
    col_d    = col_q;
    if (accept) col_d = (col_q == CW'(IMG_WIDTH - 1)) ? '0 : col_q + 1'b1;
    case (state_q)
      IDLE: if (data_valid_i) begin
        state_d  = FILL;
        in_cnt_d = PW'(1);
      end
      FILL: if (data_valid_i) begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == PW'(IMG_WIDTH)) state_d = RUN;
      end
      RUN: if (data_valid_i) begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == PW'(PIX - 1)) begin
          state_d  = FLUSH;
          fl_cnt_d = '0;
        end
      end
      FLUSH: begin
        fl_cnt_d = fl_cnt_q + 1'b1;
        if (fl_cnt_q == FW'(IMG_WIDTH)) begin
          state_d  = IDLE;
          in_cnt_d = '0;
          fl_cnt_d = '0;
          col_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Window rows: top from the older line buffer, middle from the newer one, bottom live.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = lb1_rd_q;
      win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = lb0_rd_q;
      win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = pix_in;
    end
  end

  always_comb begin
    oc_d = oc_q;
    or_d = or_q;
    if (trigger) begin
      if (oc_q == CW'(IMG_WIDTH - 1)) begin
        oc_d = '0;
        or_d = (or_q == RW'(IMG_HEIGHT - 1)) ? '0 : or_q + 1'b1;
      end else begin
        oc_d = oc_q + 1'b1;
      end
    end
    border_d = (or_q == '0) || (or_q == RW'(IMG_HEIGHT - 1)) ||
               (oc_q == '0) || (oc_q == CW'(IMG_WIDTH - 1));
    last_d   = (or_q == RW'(IMG_HEIGHT - 1)) && (oc_q == CW'(IMG_WIDTH - 1));
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_ext
    assign p[gi] = $signed({4'b0000, win_q[gi]});
  end

  always_comb begin
    gx_d = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
    gy_d = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
    ax   = gx_q[GW-1] ? -gx_q : gx_q;
    ay   = gy_q[GW-1] ? -gy_q : gy_q;
    mag  = ax + ay;
    mag_sat = (mag > GW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
    result = (mag_sat >= thresh_i) ? {DATA_W{1'b1}} : '0;
`else
    result = mag_sat;
`endif
    out_d = out_q;
    if (v1_q) out_d = border1_q ? '0 : result;
    eof_d = v1_q & last1_q;
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      in_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      oc_q      <= '0;
      or_q      <= '0;
      win_q     <= '{default: '0};
      trig_q    <= 1'b0;
      border_q  <= 1'b0;
      last_q    <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      v1_q      <= 1'b0;
      border1_q <= 1'b0;
      last1_q   <= 1'b0;
      out_q     <= '0;
      done_q    <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      in_cnt_q  <= in_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      oc_q      <= oc_d;
      or_q      <= or_d;
      win_q     <= win_d;
      trig_q    <= trigger;
      border_q  <= border_d;
      last_q    <= last_d;
      gx_q      <= gx_d;
      gy_q      <= gy_d;
      v1_q      <= trig_q;
      border1_q <= border_q;
      last1_q   <= last_q;
      out_q     <= out_d;
      done_q    <= v1_q;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
    end
  end

  assign sobel_red_o   = out_q;
  assign sobel_green_o = out_q;
  assign sobel_blue_o  = out_q;
  assign sobel_done_o  = done_q;
  assign sobel_eof_o   = eof_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x4 frame; honours SOBEL_THRESH_EN when defined.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_red_i = '0, data_green_i = '0, data_blue_i = '0, thresh_i = '0;
  logic       data_valid_i = 1'b0;
  logic [7:0] sobel_red_o, sobel_green_o, sobel_blue_o;
  logic       sobel_done_o, sobel_eof_o, busy_o;

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .data_red_i(data_red_i), .data_green_i(data_green_i), .data_blue_i(data_blue_i),
    .data_valid_i(data_valid_i), .thresh_i(thresh_i),
    .sobel_red_o(sobel_red_o), .sobel_green_o(sobel_green_o), .sobel_blue_o(sobel_blue_o),
    .sobel_done_o(sobel_done_o), .sobel_eof_o(sobel_eof_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int q_val[$];
  int q_cyc[$];
  bit q_eof[$];
  bit q_same[$];
  int acc[N];
  int busy_fall = -1;
  int fall_seen = -1;
  bit busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst && sobel_done_o) begin
      q_val.push_back(int'(sobel_red_o));
      q_cyc.push_back(cyc);
      q_eof.push_back(sobel_eof_o);
      q_same.push_back(sobel_green_o == sobel_red_o && sobel_blue_o == sobel_red_o);
      $display("out #%0d @%0d val=%0d eof=%0b", q_val.size(), cyc, sobel_red_o, sobel_eof_o);
    end
    if (busy_prev && !busy_o) busy_fall = cyc;
    busy_prev = busy_o;
  end

  function automatic logic [7:0] pix(input int kind, input int c);
    if (kind == 0) return 8'd100;
    if (kind == 1) return (c >= 4) ? 8'd255 : 8'd0;
    return (c >= 4) ? 8'd10 : 8'd0;
  endfunction

  // Hand-derived: a vertical edge between cols 3|4 only shows at interior cols 3 and 4.
  function automatic int exp_val(input int kind, input int r, input int c, input int th);
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    if (kind == 0 || !(c == 3 || c == 4)) return 0;
    if (kind == 1) return 255;
`ifdef SOBEL_THRESH_EN
    return (40 >= th) ? 255 : 0;
`else
    return 40;
`endif
  endfunction

  function automatic int trig_cyc(input int n);
    if (n + W + 1 < N) return acc[n + W + 1];
    return acc[N - 1] + (n + W + 1 - (N - 1));
  endfunction

  task automatic clear_q();
    q_val.delete(); q_cyc.delete(); q_eof.delete(); q_same.delete();
  endtask

  task automatic send_frame(input int kind, input int gap, input int count, output bit ok);
    int t = 0;
    @(negedge clk); #1;
    while (busy_o !== 1'b0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (busy_o === 1'b0);
    fall_seen = busy_fall;
    for (int i = 0; i < count; i++) begin
      data_red_i = pix(kind, i % W);
      data_green_i = pix(kind, i % W);
      data_blue_i = pix(kind, i % W);
      data_valid_i = 1'b1;
      @(negedge clk);
      acc[i] = cyc;
      if (gap != 0) begin
        data_valid_i = 1'b0;
        @(negedge clk);
      end
    end
    data_valid_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (q_val.size() < n && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_red_i = 8'(37 * i + 5); data_green_i = 8'(91 * i); data_blue_i = 8'hff;
      data_valid_i = i[0];
      @(negedge clk); #1;
      n_vec++;
      if ({sobel_red_o, sobel_green_o, sobel_blue_o, sobel_done_o, sobel_eof_o, busy_o} !== 27'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got r=%0d done=%0b eof=%0b busy=%0b, want all 0",
                 i, sobel_red_o, sobel_done_o, sobel_eof_o, busy_o);
      end
    end
    data_valid_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({sobel_red_o, sobel_green_o, sobel_blue_o, sobel_done_o, sobel_eof_o, busy_o} !== 27'd0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got r=%0d done=%0b busy=%0b, want all 0",
                 i, sobel_red_o, sobel_done_o, busy_o);
      end
    end
  endtask

  task automatic test_uniform();
    bit ok;
    clear_q();
    send_frame(0, 0, N, ok);
    wait_outputs(N);
    n_vec++;
    if (!ok || q_val.size() != N) begin
      n_err++;
      $display("FAIL uniform_count: got %0d outputs (ready=%0b), want %0d", q_val.size(), ok, N);
    end
    for (int i = 0; i < q_val.size() && i < N; i++) begin
      n_vec++;
      if (q_val[i] != 0 || q_eof[i] != (i == N - 1) || !q_same[i]) begin
        n_err++;
        $display("FAIL uniform[%0d]: got val=%0d eof=%0b same=%0b, want val=0 eof=%0b same=1",
                 i, q_val[i], q_eof[i], q_same[i], i == N - 1);
      end
    end
    n_vec++;
    if (q_cyc.size() == 0 || q_cyc[0] != acc[W + 1] + 2) begin
      n_err++;
      $display("FAIL uniform_first_latency: got cycle %0d, want %0d",
               (q_cyc.size() > 0) ? q_cyc[0] : -1, acc[W + 1] + 2);
    end
    n_vec++;
    if (busy_fall != acc[N - 1] + W + 1) begin
      n_err++;
      $display("FAIL uniform_busy_drop: got cycle %0d, want %0d", busy_fall, acc[N - 1] + W + 1);
    end
  endtask

  task automatic test_vertical_step(input int gap);
    bit ok;
    clear_q();
    send_frame(1, gap, N, ok);
    wait_outputs(N);
    n_vec++;
    if (!ok || q_val.size() != N) begin
      n_err++;
      $display("FAIL step_count(gap=%0d): got %0d outputs, want %0d", gap, q_val.size(), N);
    end
    for (int i = 0; i < q_val.size() && i < N; i++) begin
      n_vec++;
      if (q_val[i] != exp_val(1, i / W, i % W, 0) || q_eof[i] != (i == N - 1) ||
          q_cyc[i] != trig_cyc(i) + 2) begin
        n_err++;
        $display("FAIL step(gap=%0d)[%0d]: got val=%0d eof=%0b cyc=%0d, want val=%0d eof=%0b cyc=%0d",
                 gap, i, q_val[i], q_eof[i], q_cyc[i], exp_val(1, i / W, i % W, 0),
                 i == N - 1, trig_cyc(i) + 2);
      end
    end
  endtask

  task automatic test_threshold();
    bit ok;
    int nruns;
`ifdef SOBEL_THRESH_EN
    nruns = 2;
`else
    nruns = 1;
`endif
    for (int k = 0; k < nruns; k++) begin
      thresh_i = 8'(40 + k);
      clear_q();
      send_frame(2, 0, N, ok);
      wait_outputs(N);
      n_vec++;
      if (!ok || q_val.size() != N) begin
        n_err++;
        $display("FAIL thresh_count(th=%0d): got %0d outputs, want %0d", 40 + k, q_val.size(), N);
      end
      for (int i = 0; i < q_val.size() && i < N; i++) begin
        n_vec++;
        if (q_val[i] != exp_val(2, i / W, i % W, 40 + k)) begin
          n_err++;
          $display("FAIL thresh(th=%0d)[%0d]: got %0d, want %0d",
                   40 + k, i, q_val[i], exp_val(2, i / W, i % W, 40 + k));
        end
      end
    end
    thresh_i = '0;
  endtask

  task automatic test_midframe_reset();
    bit ok;
    clear_q();
    send_frame(1, 0, 10, ok);
    rst = 1'b0;
    #1;
    n_vec++;
    if (sobel_done_o !== 1'b0 || busy_o !== 1'b0 || sobel_red_o !== 8'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got done=%0b busy=%0b val=%0d, want 0 0 0",
               sobel_done_o, busy_o, sobel_red_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_vec++;
    if (q_val.size() != 0) begin
      n_err++;
      $display("FAIL midreset_residue: got %0d outputs, want 0", q_val.size());
    end
    send_frame(1, 0, N, ok);
    wait_outputs(N);
    n_vec++;
    if (!ok || q_val.size() != N) begin
      n_err++;
      $display("FAIL midreset_count: got %0d outputs, want %0d", q_val.size(), N);
    end
    for (int i = 0; i < q_val.size() && i < N; i++) begin
      n_vec++;
      if (q_val[i] != exp_val(1, i / W, i % W, 0) || q_eof[i] != (i == N - 1)) begin
        n_err++;
        $display("FAIL midreset[%0d]: got val=%0d eof=%0b, want val=%0d eof=%0b",
                 i, q_val[i], q_eof[i], exp_val(1, i / W, i % W, 0), i == N - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    clear_q();
    send_frame(1, 0, N, ok1);
    send_frame(1, 0, N, ok2);
    n_vec++;
    if (!ok1 || !ok2 || acc[0] != fall_seen + 1) begin
      n_err++;
      $display("FAIL b2b_start: got 2nd frame accept at %0d, want %0d", acc[0], fall_seen + 1);
    end
    wait_outputs(2 * N);
    n_vec++;
    if (q_val.size() != 2 * N) begin
      n_err++;
      $display("FAIL b2b_count: got %0d outputs, want %0d", q_val.size(), 2 * N);
    end
    for (int i = 0; i < q_val.size() && i < 2 * N; i++) begin
      n_vec++;
      if (q_val[i] != exp_val(1, (i % N) / W, i % W, 0) || q_eof[i] != ((i % N) == N - 1)) begin
        n_err++;
        $display("FAIL b2b[%0d]: got val=%0d eof=%0b, want val=%0d eof=%0b",
                 i, q_val[i], q_eof[i], exp_val(1, (i % N) / W, i % W, 0), (i % N) == N - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_vertical_step(0);
    test_vertical_step(1);
    test_threshold();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
